// File: rtl/bcd_down_2_speed.sv
// Multi-digit BCD down-counter with full/quarter rate stepping via a clock-enable prescaler.
// Underflow saturates at zero when BCD_DN_SATURATE_EN is defined, otherwise wraps to all nines.
module bcd_down_2_speed #(
  parameter int unsigned DIGITS = 2,
  parameter int unsigned DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sel,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   y,
  output logic                  zero,
  output logic                  step
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PreMax = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  y_q, y_d;
  logic [W-1:0]  dec_val;
  logic [W-1:0]  load_clamped;
  logic          step_q;
  logic          slow_tick;
  logic          dec;
  logic          at_zero;

  assign at_zero   = (y_q == '0);
  assign slow_tick = (pre_q == PreMax) & en;
  assign dec       = en & ~load & (sel ? slow_tick : 1'b1);

  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Borrow ripples upward; from all-zero this naturally yields all nines.
  always_comb begin
    logic borrow;
    borrow  = 1'b1;
    dec_val = y_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (y_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = y_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
`ifdef BCD_DN_SATURATE_EN
    if (at_zero) begin
      dec_val = y_q;
    end
`endif
  end

  always_comb begin
    y_d   = y_q;
    pre_d = pre_q;
    if (load) begin
      y_d   = load_clamped;
      pre_d = '0;
    end else begin
      if (dec) begin
        y_d = dec_val;
      end
      if (en) begin
        pre_d = (pre_q == PreMax) ? '0 : pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_q    <= '0;
      pre_q  <= '0;
      step_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      pre_q  <= pre_d;
      step_q <= dec;
    end
  end

  assign y    = y_q;
  assign zero = at_zero;
  assign step = step_q;

endmodule

// File: tb/tb_bcd_down_2_speed.sv
// Scoreboard bench for bcd_down_2_speed: an integer-valued reference model predicts y/zero/step
// for every cycle; predictions are queued when stimulus is driven and compared after the edge.
module tb_bcd_down_2_speed;

  localparam int unsigned DIGITS = 2;
  localparam int unsigned DIV    = 4;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] y;
    logic         zero;
    logic         step;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         en;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] y;
  logic         zero;
  logic         step;

  int checks   = 0;
  int failures = 0;

  exp_t sb_q[$];

  // Reference model state, held as plain integers
  int m_y   = 0;
  int m_pre = 0;

  bcd_down_2_speed #(
    .DIGITS (DIGITS),
    .DIV    (DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .y        (y),
    .zero     (zero),
    .step     (step)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd_clamped(input logic [W-1:0] b);
    int v;
    int d;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic int max_count();
    int m;
    m = 1;
    for (int i = 0; i < DIGITS; i++) m = m * 10;
    return m - 1;
  endfunction

  // Drive one cycle, predict its outcome, then compare after the edge
  task automatic drive(input logic s, input logic e, input logic l, input logic [W-1:0] lv);
    logic  d;
    exp_t  ex;
    exp_t  got_ex;
    sel      = s;
    en       = e;
    load     = l;
    load_val = lv;
    d = e && !l && (s ? (m_pre == DIV - 1) : 1'b1);
    if (l) begin
      m_y   = from_bcd_clamped(lv);
      m_pre = 0;
    end else begin
      if (e) m_pre = (m_pre + 1) % DIV;
      if (d) begin
`ifdef BCD_DN_SATURATE_EN
        m_y = (m_y == 0) ? 0 : m_y - 1;
`else
        m_y = (m_y == 0) ? max_count() : m_y - 1;
`endif
      end
    end
    ex.y    = to_bcd(m_y);
    ex.zero = (m_y == 0);
    ex.step = d;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    got_ex = sb_q.pop_front();
    check("y", 32'(y), 32'(got_ex.y));
    check("zero", 32'(zero), 32'(got_ex.zero));
    check("step", 32'(step), 32'(got_ex.step));
  endtask

  task automatic model_reset();
    m_y   = 0;
    m_pre = 0;
  endtask

  initial begin
    rst      = 1'b0;
    sel      = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    load_val = '0;
    #1;
    check("rst_y", 32'(y), 32'h0);
    check("rst_zero", 32'(zero), 32'h1);
    check("rst_step", 32'(step), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Fast mode with borrow across digits
    drive(1'b0, 1'b1, 1'b1, 8'h10);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Asynchronous reset while running at 37, no clock edge in between
    drive(1'b0, 1'b1, 1'b1, 8'h38);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    check("pre_async_y", 32'(y), 32'h37);
    #2;
    rst = 1'b0;
    #1;
    check("async_y", 32'(y), 32'h0);
    check("async_zero", 32'(zero), 32'h1);
    check("async_step", 32'(step), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // Slow mode: 05 holds three edges, 04 on 4th, 03 on 8th
    drive(1'b1, 1'b1, 1'b1, 8'h05);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("slow_y8", 32'(y), 32'h03);

    // Underflow from 01
    drive(1'b0, 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);

    // Load beats a pending slow decrement and clamps the nibble; prescaler restarts
    drive(1'b1, 1'b1, 1'b1, 8'h20);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h3C);
    check("clamp_y", 32'(y), 32'h39);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("clamp_next_y", 32'(y), 32'h38);

    // Enable freeze in slow mode
    drive(1'b1, 1'b1, 1'b1, 8'h50);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("freeze_y", 32'(y), 32'h49);

    // Mixed random traffic, including sel changes mid-prescale
    for (int i = 0; i < 200; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 15) == 0), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_down_2_speed.md
# bcd_down_2_speed

Multi-digit BCD down-counter with a selectable full/quarter stepping rate. It is the count-down counterpart of the team's two-speed BCD up-counter and is intended for countdown timers feeding the same display path. Rate selection is done with a clock-enable prescaler instead of a muxed clock, so the whole block runs on a single clock domain. A loadable start value and a zero flag let it serve as a programmable timer.

## Interface
- DIGITS, 2, number of BCD digits (1..8)
- DIV, 4, slow-rate divide ratio (≥2); slow mode steps once per DIV enabled cycles
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- sel  in  1  rate select: 0 = step every enabled cycle, 1 = step every DIV enabled cycles
- en  in  1  count enable; 0 freezes count and prescaler
- load  in  1  synchronous load strobe
- load_val  in  4*DIGITS  start value, digit 0 in bits [3:0]
- y  out  4*DIGITS  current BCD count, registered
- zero  out  1  high while y == 0 (decoded from y register, no added latency)
- step  out  1  registered one-cycle pulse, high in the cycle after a decrement occurred

## Operation
- Reset (rst=0, async): y=0, zero=1, step=0, prescaler=0. Reset asserted mid-count clears immediately, without waiting for a clock edge. Release is synchronous to the next edge.
- Prescaler: counts 0..DIV-1, advancing only when en=1 and load=0. Wraps DIV-1→0. slow_tick = (prescaler == DIV-1) & en.
- Decrement condition: dec = en & !load & (sel ? slow_tick : 1).
- Priority per edge: reset > load > dec > hold.
- Load: y ← load_val and prescaler ← 0. Any digit > 9 is clamped to 9 (e.g. 0xC→0x9). The zero flag follows the loaded value.
- Decrement: per-digit borrow chain. Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit. Digits stay within 0..9 at all times.
- Underflow (y == 0 and dec): behaviour set by the configuration macro.
- step = registered dec. It is also asserted on a saturated (no-change) decrement.
- sel changes take effect on the next edge. The prescaler is not reset on sel changes.
- en=0: y, prescaler and zero hold; step=0 on the following cycle.

## Timing
- Load latency: 1 edge. y equals load_val (clamped) after the edge that samples load=1.
- Fast mode (sel=0, en=1): y decrements on every rising edge.
- Slow mode (sel=1) after load or reset: first decrement on the DIV-th enabled edge, then every DIV enabled edges.
- zero: combinational from the y register. It is valid in the same cycle y becomes 0.
- step: high during the cycle following the edge at which the decrement took effect.

## Configuration
- BCD_DN_SATURATE_EN defined: when y == 0, a dec leaves y at 0 (saturates) and zero stays 1.
- BCD_DN_SATURATE_EN undefined (default): when y == 0, a dec wraps y to all nines (e.g. 8'h99 for DIGITS=2) and zero falls.

## Test plan
(DIGITS=2, DIV=4.)
- Reset: count running at 8'h37, pull rst low between edges → y=8'h00, zero=1 immediately, with no clock edge.
- Load and fast mode: load 8'h10, sel=0, en=1 → y = 10, 09, 08 on successive edges (borrow across digits); step high each cycle after a decrement.
- Slow mode: load 8'h05, sel=1, en=1 → y holds 05 for 3 edges, 04 on the 4th edge, 03 on the 8th edge.
- Underflow: load 8'h01, sel=0 → 00 with zero=1, then 99 with zero=0 on the next edge. With BCD_DN_SATURATE_EN defined, y stays 00 and step still pulses.
- Load priority and clamping: assert load with load_val=8'h3C while dec would fire → y=8'h39 and the prescaler restarts, so the next slow step comes 4 edges later.
- Enable freeze: sel=1, drop en after 2 enabled edges for 5 cycles, then reassert → y and step frozen while en=0; decrement occurs after 2 more enabled edges.
